// File: rtl/rob_pkg.sv
// rob_pkg: entry layout, default widths and age helper shared by the reorder buffer files.
package rob_pkg;
  localparam int RA_W = 5;
  localparam int D_W = 32;
  localparam int ID_W = 3;
  localparam int N = 2 ** ID_W;
  typedef struct packed {
    logic valid;
    logic done;
    logic w;
    logic [RA_W-1:0] dest;
    logic [D_W-1:0] value;
  } entry_t;
  function automatic logic [ID_W-1:0] age(input logic [ID_W-1:0] idx, input logic [ID_W-1:0] head);
    return idx - head;
  endfunction
endpackage

// File: rtl/rob_lookup.sv
// rob_lookup: youngest pending producer of a register, with same-cycle completion bypass.
module rob_lookup import rob_pkg::*; (
  input  entry_t           i_ent [N],
  input  logic [ID_W-1:0]  i_head,
  input  logic [RA_W-1:0]  i_addr,
  input  logic             i_alu_valid,
  input  logic [ID_W-1:0]  i_alu_id,
  input  logic [D_W-1:0]   i_alu_value,
  input  logic             i_mul_valid,
  input  logic [ID_W-1:0]  i_mul_id,
  input  logic [D_W-1:0]   i_mul_value,
  input  logic             i_mem_valid,
  input  logic [ID_W-1:0]  i_mem_id,
  input  logic [D_W-1:0]   i_mem_value,
  output logic             o_dep,
  output logic             o_res,
  output logic [D_W-1:0]   o_value
);
  logic w_found;
  logic [ID_W-1:0] w_idx;
  logic [ID_W-1:0] w_age;
  logic w_alu_hit;
  logic w_mul_hit;
  logic w_mem_hit;
  always_comb begin
    w_found = 1'b0;
    w_idx = '0;
    w_age = '0;
    for (int i = 0; i < N; i++)
      if (i_ent[i].valid && i_ent[i].w && i_ent[i].dest == i_addr && i_addr != '0 &&
          (!w_found || age(ID_W'(i), i_head) > w_age)) begin
        w_found = 1'b1;
        w_idx = ID_W'(i);
        w_age = age(ID_W'(i), i_head);
      end
  end
  assign w_alu_hit = i_alu_valid && i_alu_id == w_idx;
  assign w_mul_hit = i_mul_valid && i_mul_id == w_idx;
  assign w_mem_hit = i_mem_valid && i_mem_id == w_idx;
  assign o_dep = w_found;
  assign o_res = w_found && (w_alu_hit || w_mul_hit || w_mem_hit || i_ent[w_idx].done);
  assign o_value = !w_found ? '0 :
                   w_alu_hit ? i_alu_value :
                   w_mul_hit ? i_mul_value :
                   w_mem_hit ? i_mem_value :
                   i_ent[w_idx].done ? i_ent[w_idx].value : '0;
endmodule

// File: rtl/rob.sv
// rob: reorder buffer; allocates in decode order, collects ALU/MUL/MEM results, retires in order.
module rob import rob_pkg::*; #(
  parameter int REG_ADDRESS_SIZE = RA_W,
  parameter int REG_SIZE = D_W,
  parameter int ID_SIZE = ID_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alloc_valid,
  input  logic [ID_SIZE-1:0]          alloc_id,
  input  logic                        alloc_w,
  input  logic [REG_ADDRESS_SIZE-1:0] alloc_dest,
  input  logic                        alloc_done,
  input  logic                        alu_valid,
  input  logic [ID_SIZE-1:0]          alu_id,
  input  logic [REG_SIZE-1:0]         alu_value,
  input  logic                        mul_valid,
  input  logic [ID_SIZE-1:0]          mul_id,
  input  logic [REG_SIZE-1:0]         mul_value,
  input  logic                        mem_valid,
  input  logic [ID_SIZE-1:0]          mem_id,
  input  logic [REG_SIZE-1:0]         mem_value,
  input  logic [REG_ADDRESS_SIZE-1:0] dAddr1,
  input  logic [REG_ADDRESS_SIZE-1:0] dAddr2,
  output logic                        dependency1,
  output logic                        dependency2,
  output logic                        resolved1,
  output logic                        resolved2,
  output logic [REG_SIZE-1:0]         dValue1,
  output logic [REG_SIZE-1:0]         dValue2,
  output logic                        rob_stall,
  output logic                        commit_We,
  output logic [REG_ADDRESS_SIZE-1:0] commit_Wat,
  output logic [REG_SIZE-1:0]         commit_Wvalue,
  output logic [ID_SIZE-1:0]          head
);
  entry_t r_ent [N];
  logic [ID_SIZE-1:0] r_head;
  logic [ID_SIZE:0] r_count;
  logic w_fire;
  logic [ID_SIZE-1:0] w_tail;
  assign w_fire = r_ent[r_head].valid && r_ent[r_head].done;
  assign w_tail = r_head + r_count[ID_SIZE-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ent <= '{default: '0};
      r_head <= '0;
      r_count <= '0;
    end else begin
      if (alu_valid && r_ent[alu_id].valid) begin
        r_ent[alu_id].done <= 1'b1;
        r_ent[alu_id].value <= alu_value;
      end
      if (mul_valid && r_ent[mul_id].valid) begin
        r_ent[mul_id].done <= 1'b1;
        r_ent[mul_id].value <= mul_value;
      end
      if (mem_valid && r_ent[mem_id].valid) begin
        r_ent[mem_id].done <= 1'b1;
        r_ent[mem_id].value <= mem_value;
      end
      if (w_fire) r_ent[r_head].valid <= 1'b0;
      // allocation is written last so it wins over any completion to the same slot
      if (alloc_valid)
        r_ent[alloc_id] <= '{valid: 1'b1, done: alloc_done, w: alloc_w, dest: alloc_dest, value: '0};
      r_head <= r_head + ID_SIZE'(w_fire);
      r_count <= r_count + (ID_SIZE+1)'(alloc_valid) - (ID_SIZE+1)'(w_fire);
    end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      if (alloc_valid) assert (alloc_id == w_tail);
      assert (!(alu_valid && mul_valid && alu_id == mul_id) &&
              !(alu_valid && mem_valid && alu_id == mem_id) &&
              !(mul_valid && mem_valid && mul_id == mem_id));
    end
  assign rob_stall = r_count == (ID_SIZE+1)'(N);
  assign commit_We = w_fire && r_ent[r_head].w && r_ent[r_head].dest != '0;
  assign commit_Wat = r_ent[r_head].dest;
  assign commit_Wvalue = r_ent[r_head].value;
  assign head = r_head;
  rob_lookup u_look1 (
    .i_ent(r_ent), .i_head(r_head), .i_addr(dAddr1),
    .i_alu_valid(alu_valid), .i_alu_id(alu_id), .i_alu_value(alu_value),
    .i_mul_valid(mul_valid), .i_mul_id(mul_id), .i_mul_value(mul_value),
    .i_mem_valid(mem_valid), .i_mem_id(mem_id), .i_mem_value(mem_value),
    .o_dep(dependency1), .o_res(resolved1), .o_value(dValue1)
  );
  rob_lookup u_look2 (
    .i_ent(r_ent), .i_head(r_head), .i_addr(dAddr2),
    .i_alu_valid(alu_valid), .i_alu_id(alu_id), .i_alu_value(alu_value),
    .i_mul_valid(mul_valid), .i_mul_id(mul_id), .i_mul_value(mul_value),
    .i_mem_valid(mem_valid), .i_mem_id(mem_id), .i_mem_value(mem_value),
    .o_dep(dependency2), .o_res(resolved2), .o_value(dValue2)
  );
endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer directly downstream of the decode/dispatch stage.
- Allocates one entry per dispatched slot, in the order of the decode tail ID.
- Collects results from the ALU, MUL and MEM writeback ports and retires entries in order. Retirement drives the register-bank write port (Wat/Wvalue/We) back into decode.
- Answers decode's two operand dependency lookups (dependency/resolved/value) and raises rob_stall when full.

Parameters:
REG_ADDRESS_SIZE, 5, register index width
REG_SIZE, 32, data width
ID_SIZE, 3, entry-ID width; depth N = 2**ID_SIZE

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
alloc_valid  in  1  allocate this cycle (decode drives !stall && !take_branch)
alloc_id  in  ID_SIZE  decode tail; entry index to allocate
alloc_w  in  1  entry writes a register
alloc_dest  in  REG_ADDRESS_SIZE  destination register
alloc_done  in  1  entry needs no unit (bubble/nop): complete at allocation
alu_valid, mul_valid, mem_valid  in  1 each  completion strobes
alu_id, mul_id, mem_id  in  ID_SIZE each  completing entry
alu_value, mul_value, mem_value  in  REG_SIZE each  results
dAddr1, dAddr2  in  REG_ADDRESS_SIZE each  lookup registers
dependency1, dependency2  out  1 each  a pending entry targets dAddrN
resolved1, resolved2  out  1 each  that entry's value is available
dValue1, dValue2  out  REG_SIZE each  that value
rob_stall  out  1  buffer full
commit_We  out  1  register-bank write enable
commit_Wat  out  REG_ADDRESS_SIZE  register-bank write address
commit_Wvalue  out  REG_SIZE  register-bank write data
head  out  ID_SIZE  oldest entry ID

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-high, and overrides everything else that cycle.
- Reset state: all valid/done bits 0, head=0, count=0. All outputs are 0 during and after reset.
- Entry fields: valid, done, w, dest, value.
- Allocation (posedge, alloc_valid=1):
  - entry[alloc_id] <= {valid=1, done=alloc_done, w=alloc_w, dest, value=0}.
  - alloc_id must equal (head+count) mod N. A mismatch is an assertion failure, not a recovery path.
- Completion (posedge, per port with valid=1):
  - If entry[id].valid, set done=1 and latch the value.
  - If the entry is not valid, ignore the strobe.
  - Different ports hitting the same id in one cycle is illegal and asserted.
  - Allocate and complete on the same id in one cycle cannot occur when not full; if it does, allocation wins.
- Commit (combinational): commit_fire = entry[head].valid && entry[head].done.
  - commit_We = commit_fire && w && dest!=0.
  - commit_Wat = entry[head].dest; commit_Wvalue = entry[head].value.
  - On the posedge with commit_fire: clear valid[head], head <= head+1 (wraps mod N), count decrements.
  - At most one retirement per cycle; entries with w=0 retire silently.
- count update: count <= count + alloc_valid - commit_fire. Simultaneous allocation and commit leaves count unchanged.
- rob_stall = (count == N), computed from registered state only, so there is no combinational loop through decode.
  - When full and committing in the same cycle, rob_stall stays 1 that cycle (conservative).
- Lookup port k:
  - Scan valid entries with w=1, dest==dAddrk and dAddrk!=0. Pick the youngest by age=(idx-head) mod N.
  - dependencyk = match found.
  - resolvedk = youngest.done, or a completion strobe this cycle whose id equals the youngest's idx (same-cycle bypass; the strobe's value is forwarded).
  - dValuek = the bypassed value, else youngest.value. Unresolved or absent: resolvedk=0, dValuek=0.
  - An entry retiring this cycle still counts as a match; decode's own Wat bypass also covers that case.
- Latency:
  - Completion at edge k makes resolved=1 combinationally in cycle k via bypass, and from registered state after edge k.
  - commit_We is asserted in the cycle after edge k if the entry is the head.
  - The register bank is written at edge k+1.
- Wrap-around: head and IDs use natural ID_SIZE overflow. Age arithmetic is modulo N.

Decomposition:
- Shared package rob_pkg:
  - entry struct {valid, done, w, dest, value}
  - localparam N = 2**ID_SIZE
  - function age(idx, head)
- Sub-module rob_lookup: one instance per lookup port. Pure combinational youngest-match plus bypass against the three completion ports.
- rob owns the storage, head/count and commit.

Test Plan:
1. Reset: assert reset with 3 entries live -> next cycle count=0, rob_stall=0, commit_We=0, dependency1=0.
2. In-order retire: alloc id0 (w=1, dest=5), alloc id1 (w=1, dest=6), complete id1 via MUL with 0x22, then id0 via ALU with 0x11 -> commits r5=0x11 then r6=0x22 on consecutive cycles, never r6 first.
3. Youngest match and bypass:
   - alloc id0 dest=3, alloc id1 dest=3, dAddr1=3 -> dependency1=1, resolved1=0.
   - alu_valid, id=1, value=0xAB in the same cycle -> resolved1=1, dValue1=0xAB; id0 is ignored.
4. Full and wrap:
   - N=8: allocate 8 entries -> rob_stall=1.
   - Complete head -> retire; after 8 more alloc/commit pairs head wraps 7->0 with correct data.
5. Silent and r0 entries: alloc_done=1 with w=0, and an entry with dest=0 -> both retire with commit_We=0; dAddr=0 gives dependency=0.
6. Stray completion: mem_valid to an unallocated id -> no state change, no commit.
